// File: rtl/tournament_branch_predictor.sv
// Tournament IF-stage predictor: bimodal + gshare PHTs, chooser, tagged direct-mapped BTB.
// Optional return address stack is built when the RAS_EN macro is defined.
module tournament_branch_predictor #(
  parameter int S_INDEX   = 8,
  parameter int HIST_LEN  = 8,
  parameter int BTB_INDEX = 6,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_if_valid,
  input  logic [31:0]                  i_if_pc,
  output logic                         o_if_pred_taken,
  output logic [31:0]                  o_if_pred_target,
  output logic                         o_if_btb_hit,
  output logic [HIST_LEN-1:0]          o_if_ghr,
  output logic [$clog2(RAS_DEPTH)-1:0] o_if_ras_ptr,
  input  logic                         i_mem_valid,
  input  logic [31:0]                  i_mem_pc,
  input  logic                         i_mem_is_branch,
  input  logic                         i_mem_is_jump,
  input  logic                         i_mem_is_call,
  input  logic                         i_mem_is_ret,
  input  logic                         i_mem_actual_taken,
  input  logic [31:0]                  i_mem_actual_target,
  input  logic                         i_mem_pred_taken,
  input  logic [31:0]                  i_mem_pred_target,
  input  logic [HIST_LEN-1:0]          i_mem_ghr,
  input  logic [$clog2(RAS_DEPTH)-1:0] i_mem_ras_ptr,
  output logic                         o_mem_mispredict,
  output logic [31:0]                  o_mem_redirect_pc
);
  localparam int PHT_N  = 1 << S_INDEX;
  localparam int BTB_N  = 1 << BTB_INDEX;
  localparam int TAG_W  = 30 - BTB_INDEX;
  localparam int RAS_PW = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {T_BR = 2'd0, T_JMP = 2'd1, T_CALL = 2'd2, T_RET = 2'd3} btb_type_e;

  logic [1:0]          r_pht_l      [PHT_N];
  logic [1:0]          r_pht_g      [PHT_N];
  logic [1:0]          r_chooser    [PHT_N];
  logic                r_btb_valid  [BTB_N];
  logic [TAG_W-1:0]    r_btb_tag    [BTB_N];
  logic [31:0]         r_btb_target [BTB_N];
  btb_type_e           r_btb_type   [BTB_N];
  logic [HIST_LEN-1:0] r_ghr;

  logic [S_INDEX-1:0]   w_if_l_idx, w_if_g_idx, w_mem_l_idx, w_mem_g_idx;
  logic [BTB_INDEX-1:0] w_if_btb_idx, w_mem_btb_idx;
  logic [31:0]          w_if_pc4, w_mem_pc4;
  logic                 w_if_hit, w_if_br_hit, w_br_taken, w_l_ok, w_g_ok;
  btb_type_e            w_mem_type;

  function automatic logic [1:0] sat2(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
    else    return (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
  endfunction

  assign w_if_l_idx   = i_if_pc[S_INDEX+1:2];
  assign w_if_g_idx   = w_if_l_idx ^ S_INDEX'(r_ghr);
  assign w_if_btb_idx = i_if_pc[BTB_INDEX+1:2];
  assign w_if_pc4     = i_if_pc + 32'd4;
  assign w_if_hit     = r_btb_valid[w_if_btb_idx] && (r_btb_tag[w_if_btb_idx] == i_if_pc[31:BTB_INDEX+2]);
  assign w_br_taken   = r_chooser[w_if_l_idx][1] ? r_pht_g[w_if_g_idx][1] : r_pht_l[w_if_l_idx][1];
  assign o_if_btb_hit = w_if_hit;
  assign o_if_ghr     = r_ghr;

  // Second read port: MEM-side indices judge pre-update correctness of each PHT
  assign w_mem_l_idx   = i_mem_pc[S_INDEX+1:2];
  assign w_mem_g_idx   = w_mem_l_idx ^ S_INDEX'(i_mem_ghr);
  assign w_mem_btb_idx = i_mem_pc[BTB_INDEX+1:2];
  assign w_mem_pc4     = i_mem_pc + 32'd4;
  assign w_l_ok        = (r_pht_l[w_mem_l_idx][1] == i_mem_actual_taken);
  assign w_g_ok        = (r_pht_g[w_mem_g_idx][1] == i_mem_actual_taken);

  assign o_mem_mispredict  = i_mem_valid & ~i_rst &
                             ((i_mem_actual_taken != i_mem_pred_taken) |
                              (i_mem_actual_taken & (i_mem_actual_target != i_mem_pred_target)));
  assign o_mem_redirect_pc = i_mem_actual_taken ? i_mem_actual_target : w_mem_pc4;

`ifdef RAS_EN
  logic [31:0]       r_ras [RAS_DEPTH];
  logic [RAS_PW-1:0] r_ras_ptr;
  logic [RAS_PW:0]   r_ras_cnt;
  logic [RAS_PW-1:0] w_ras_top_idx;
  logic              w_ras_push, w_ras_pop;

  assign w_ras_top_idx = r_ras_ptr - RAS_PW'(1);
  assign o_if_ras_ptr  = r_ras_ptr;
`else
  logic w_unused;

  assign w_unused     = ^i_mem_ras_ptr;
  assign o_if_ras_ptr = {RAS_PW{1'b0}};
`endif

  // Combinational IF lookup
  always_comb begin
    o_if_pred_taken  = 1'b0;
    o_if_pred_target = w_if_pc4;
    w_if_br_hit      = 1'b0;
`ifdef RAS_EN
    w_ras_push = 1'b0;
    w_ras_pop  = 1'b0;
`endif
    if (w_if_hit) begin
      case (r_btb_type[w_if_btb_idx])
        T_BR: begin
          w_if_br_hit     = 1'b1;
          o_if_pred_taken = w_br_taken;
          if (w_br_taken) o_if_pred_target = r_btb_target[w_if_btb_idx];
          else            o_if_pred_target = w_if_pc4;
        end
        T_JMP: begin
          o_if_pred_taken  = 1'b1;
          o_if_pred_target = r_btb_target[w_if_btb_idx];
        end
        T_CALL: begin
          o_if_pred_taken  = 1'b1;
          o_if_pred_target = r_btb_target[w_if_btb_idx];
`ifdef RAS_EN
          w_ras_push = i_if_valid;
`endif
        end
        T_RET: begin
          o_if_pred_taken  = 1'b1;
          o_if_pred_target = r_btb_target[w_if_btb_idx];
`ifdef RAS_EN
          if (r_ras_cnt != {(RAS_PW+1){1'b0}}) begin
            o_if_pred_target = r_ras[w_ras_top_idx];
            w_ras_pop        = i_if_valid;
          end else begin
            w_ras_pop = 1'b0;
          end
`endif
        end
        default: begin
          o_if_pred_taken  = 1'b0;
          o_if_pred_target = w_if_pc4;
        end
      endcase
    end else begin
      o_if_pred_taken  = 1'b0;
      o_if_pred_target = w_if_pc4;
    end
  end

  // Resolved instruction kind for BTB allocation, RET > CALL > JMP > BR
  always_comb begin
    if (i_mem_is_ret)       w_mem_type = T_RET;
    else if (i_mem_is_call) w_mem_type = T_CALL;
    else if (i_mem_is_jump) w_mem_type = T_JMP;
    else                    w_mem_type = T_BR;
  end

  // PHT, chooser and BTB training from MEM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < PHT_N; i++) begin
        r_pht_l[i]   <= 2'b01;
        r_pht_g[i]   <= 2'b01;
        r_chooser[i] <= 2'b01;
      end
      for (int i = 0; i < BTB_N; i++) r_btb_valid[i] <= 1'b0;
    end else begin
      if (i_mem_valid && i_mem_is_branch) begin
        r_pht_l[w_mem_l_idx] <= sat2(r_pht_l[w_mem_l_idx], i_mem_actual_taken);
        r_pht_g[w_mem_g_idx] <= sat2(r_pht_g[w_mem_g_idx], i_mem_actual_taken);
        if (w_g_ok && !w_l_ok)      r_chooser[w_mem_l_idx] <= sat2(r_chooser[w_mem_l_idx], 1'b1);
        else if (w_l_ok && !w_g_ok) r_chooser[w_mem_l_idx] <= sat2(r_chooser[w_mem_l_idx], 1'b0);
      end
      if (i_mem_valid && i_mem_actual_taken) begin
        r_btb_valid[w_mem_btb_idx]  <= 1'b1;
        r_btb_tag[w_mem_btb_idx]    <= i_mem_pc[31:BTB_INDEX+2];
        r_btb_target[w_mem_btb_idx] <= i_mem_actual_target;
        r_btb_type[w_mem_btb_idx]   <= w_mem_type;
      end
    end
  end

  // Speculative GHR; repair from the MEM snapshot overrides the same-cycle IF shift
  always_ff @(posedge i_clk) begin
    if (i_rst)                                    r_ghr <= {HIST_LEN{1'b0}};
    else if (o_mem_mispredict && i_mem_is_branch) r_ghr <= {i_mem_ghr[HIST_LEN-2:0], i_mem_actual_taken};
    else if (o_mem_mispredict && i_mem_is_jump)   r_ghr <= i_mem_ghr;
    else if (i_if_valid && w_if_br_hit)           r_ghr <= {r_ghr[HIST_LEN-2:0], o_if_pred_taken};
  end

`ifdef RAS_EN
  // Circular return stack; the count saturates so the oldest entry is silently overwritten
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ras_ptr <= {RAS_PW{1'b0}};
      r_ras_cnt <= {(RAS_PW+1){1'b0}};
    end else if (o_mem_mispredict) begin
      if (i_mem_is_call) begin
        r_ras_ptr <= i_mem_ras_ptr + RAS_PW'(1);
        if (r_ras_cnt != (RAS_PW+1)'(RAS_DEPTH)) r_ras_cnt <= r_ras_cnt + (RAS_PW+1)'(1);
      end else if (i_mem_is_ret) begin
        r_ras_ptr <= i_mem_ras_ptr - RAS_PW'(1);
        if (r_ras_cnt != {(RAS_PW+1){1'b0}}) r_ras_cnt <= r_ras_cnt - (RAS_PW+1)'(1);
      end else begin
        r_ras_ptr <= i_mem_ras_ptr;
      end
    end else if (w_ras_push) begin
      r_ras[r_ras_ptr] <= w_if_pc4;
      r_ras_ptr        <= r_ras_ptr + RAS_PW'(1);
      if (r_ras_cnt != (RAS_PW+1)'(RAS_DEPTH)) r_ras_cnt <= r_ras_cnt + (RAS_PW+1)'(1);
    end else if (w_ras_pop) begin
      r_ras_ptr <= w_ras_top_idx;
      r_ras_cnt <= r_ras_cnt - (RAS_PW+1)'(1);
    end
  end
`endif

endmodule

// File: doc/tournament_branch_predictor.md
Name: tournament_branch_predictor

Overview:
Parametrised next-generation IF-stage predictor. Combines a bimodal (local) PHT, a gshare (global) PHT, a chooser table and a tagged direct-mapped BTB. Lookup is combinational in IF. Training and misprediction repair are driven from MEM and take effect at the clock edge. The speculative global history register (GHR) is repaired from a snapshot carried down the pipeline.

Parameters:
S_INDEX, 8, log2 entries of each PHT and of the chooser
HIST_LEN, 8, GHR bits (must be ≤ S_INDEX)
BTB_INDEX, 6, log2 BTB entries
RAS_DEPTH, 8, return stack entries (power of 2; used only with RAS_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
if_valid  in  1  IF fetch advances this cycle (0 = stall)
if_pc  in  32  fetch PC
if_pred_taken  out  1  predicted taken
if_pred_target  out  32  predicted next PC
if_btb_hit  out  1  BTB tag match
if_ghr  out  HIST_LEN  GHR value used for this lookup (pipelined to MEM)
if_ras_ptr  out  log2(RAS_DEPTH)  RAS TOS snapshot (0 without RAS_EN)
mem_valid  in  1  MEM holds a control-flow instruction
mem_pc  in  32  its PC
mem_is_branch  in  1  conditional branch
mem_is_jump  in  1  jal/jalr
mem_is_call  in  1  jump writing x1/x5
mem_is_ret  in  1  jalr rs1=x1/x5, rd=x0
mem_actual_taken  in  1  resolved outcome (1 for jumps)
mem_actual_target  in  32  resolved target
mem_pred_taken  in  1  prediction made in IF
mem_pred_target  in  32  target predicted in IF
mem_ghr  in  HIST_LEN  if_ghr snapshot
mem_ras_ptr  in  log2(RAS_DEPTH)  if_ras_ptr snapshot
mem_mispredict  out  1  flush request
mem_redirect_pc  out  32  correct next PC

Behaviour:
- Indices
  - PHT_L/chooser: pc[S_INDEX+1:2].
  - PHT_G: pc[S_INDEX+1:2] XOR zero-extended GHR.
  - BTB index pc[BTB_INDEX+1:2]; tag pc[31:BTB_INDEX+2].
- BTB entry: valid, tag, target[31:0], type {BR, JMP, CALL, RET}.
- Lookup (combinational, 0 cycles)
  - miss: not taken, target if_pc+4.
  - JMP/CALL hit: taken, BTB target.
  - BR hit: chooser[1] selects the PHT_G MSB, else the PHT_L MSB; taken → BTB target, else if_pc+4.
- 2-bit counters saturate at 0 and 3 (no wrap). Reset value 2'b01 for PHT_L, PHT_G and chooser. Reset clears all BTB valid bits. GHR resets to 0.
- GHR speculative update: when if_valid & BR hit, GHR <= {GHR[HIST_LEN-2:0], if_pred_taken}.
- Mispredict, computed combinationally:
  - mem_mispredict = mem_valid & ~rst & (actual_taken≠pred_taken | (actual_taken & actual_target≠pred_target)).
  - mem_redirect_pc = actual_taken ? mem_actual_target : mem_pc+4.
- GHR repair
  - On mispredict of a branch: GHR <= {mem_ghr[HIST_LEN-2:0], mem_actual_taken}.
  - On mispredict of a jump: GHR <= mem_ghr.
  - Repair has priority over the same-cycle IF shift, which is discarded.
- Training at the edge when mem_valid & mem_is_branch:
  - PHT_L[idx] and PHT_G[idx(mem_ghr)] move toward actual.
  - Chooser moves toward global when only PHT_G was correct, toward local when only PHT_L was correct; otherwise unchanged.
  - Correctness is judged on pre-update counter MSBs, read through a second combinational read port.
- BTB write when mem_valid & mem_actual_taken: valid=1, tag, target, type from mem_is_* (RET > CALL > JMP > BR). A not-taken branch that misses the BTB is not allocated.
- Same-cycle IF read and MEM write to the same entry: IF sees the old contents (write-first not required).
- rst asserted mid-operation: all state reinitialised that edge; outputs reflect reset state the next cycle; mem_mispredict is forced 0 while rst=1.

Optional Feature:
RAS_EN
- Defined: circular return stack of RAS_DEPTH × 32 with TOS pointer.
  - CALL hit with if_valid: push if_pc+4.
  - RET hit with if_valid and non-empty: pop and predict the top entry instead of the BTB target.
  - Empty stack: use the BTB target.
  - Push when full overwrites the oldest entry (pointer wraps; count saturates at RAS_DEPTH).
  - On mispredict: pointer <= mem_ras_ptr, adjusted +1 if mem_is_call, −1 if mem_is_ret. Entry contents are not repaired.
- Undefined: no stack; RET is predicted from the BTB target; if_ras_ptr = 0; mem_ras_ptr is ignored.

Test Plan:
- Reset, then lookup if_pc=0x100 → if_btb_hit=0, if_pred_taken=0, if_pred_target=0x104, if_ghr=0.
- Taken branch at 0x200→0x180 resolved with pred_taken=0 → mem_mispredict=1, redirect 0x180. Next lookup 0x200 → hit, PHT_L=2 → taken, target 0x180.
- Same branch resolved not-taken 3× in a row → PHT_L saturates at 0, never underflows. Resolved taken 4× → saturates at 3.
- Alternating T/N branch with HIST_LEN=8 over 64 iterations → chooser migrates to ≥2; last 16 predictions all correct.
- IF BR-hit shift and MEM branch mispredict in the same cycle with mem_ghr=0x5A, actual=1 → GHR=0xB5; the IF shift is dropped.
- RAS_EN, RAS_DEPTH=8: 9 nested calls, then 9 returns → first 8 returns predict correct addresses, 9th falls back to the BTB target. Mispredict with mem_ras_ptr=3 on a call → pointer=4.
